force_release_responder: RTL and testbench



---
 rtl/force_responder_pkg.sv | 27 ++
 rtl/force_release_timer.sv | 31 +++
 rtl/force_release_responder.sv | 135 +++++++++++++
 tb/tb_force_release_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/force_responder_pkg.sv
// Shared types for the force/release responder: command opcodes, response
// status codes and the override state encoding.
package force_responder_pkg;

  localparam int unsigned FORCE_CNT_W = 16;

  typedef enum logic [1:0] {
    OP_FORCE   = 2'd0,
    OP_RELEASE = 2'd1,
    OP_READ    = 2'd2,
    OP_RSVD    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK         = 2'd0,
    ST_NOT_FORCED = 2'd1,
    ST_FORCED     = 2'd2,
    ST_BAD_OP     = 2'd3
  } status_e;

  typedef enum logic [1:0] {
    S_UNFORCED     = 2'd0,
    S_FORCED_HOLD  = 2'd1,
    S_FORCED_TIMED = 2'd2
  } state_e;

endpackage

// File: rtl/force_release_timer.sv
// Auto-release down-counter: load wins over clear, clear wins over decrement.
// expire_c flags the edge on which a decrementing count leaves 1.
module force_release_timer #(
  parameter int unsigned TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic               clr,
  input  logic               dec,
  output logic               expire_c
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (clr) begin
      count <= '0;
    end else if (dec && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign expire_c = dec && (count == TIMER_W'(1));

endmodule

// File: rtl/force_release_responder.sv
// Force/release target for one clocked register, driven by a valid/ready
// command channel with one response per accepted command.
// Optional build macro FORCE_RESPONDER_STATS_EN adds a saturating FORCE counter.
module force_release_responder
  import force_responder_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMER_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   d_i,
  output logic [WIDTH-1:0]   q_o,
  output logic               forced_o,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [WIDTH-1:0]   cmd_value_i,
  input  logic [TIMER_W-1:0] cmd_cycles_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [1:0]         rsp_status_o,
  output logic [WIDTH-1:0]   rsp_data_o
`ifdef FORCE_RESPONDER_STATS_EN
  ,
  output logic [FORCE_CNT_W-1:0] force_cnt_o
`endif
);

  state_e            state, state_d;
  op_e               op;
  logic              accept, is_force, is_release, is_forced, expire_c;
  logic [WIDTH-1:0]  q_d, rsp_data_d, read_data;
  logic              rsp_valid_d;
  status_e           rsp_status_d;

  assign cmd_ready_o = !rsp_valid_o || rsp_ready_i;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign op          = op_e'(cmd_op_i);
  assign is_force    = accept && (op == OP_FORCE);
  assign is_release  = accept && (op == OP_RELEASE);
  assign is_forced   = (state != S_UNFORCED);

  force_release_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (is_force),
    .load_val (cmd_cycles_i),
    .clr      (is_release),
    .dec      (state == S_FORCED_TIMED),
    .expire_c (expire_c)
  );

`ifdef FORCE_RESPONDER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      force_cnt_o <= '0;
    end else if (is_force && (force_cnt_o != '1)) begin
      force_cnt_o <= force_cnt_o + FORCE_CNT_W'(1);
    end
  end

  // Count occupies the top bits of READ data when there is room for it.
  if (WIDTH >= 32) begin : g_rd_stats
    assign read_data = {force_cnt_o, q_o[WIDTH-FORCE_CNT_W-1:0]};
  end else begin : g_rd_plain
    assign read_data = q_o;
  end
`else
  assign read_data = q_o;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_UNFORCED;
    end else begin
      state <= state_d;
    end
  end

  // A FORCE on the expiry edge takes priority over the auto-release.
  always_comb begin
    state_d = state;
    if (is_force) begin
      state_d = (cmd_cycles_i == '0) ? S_FORCED_HOLD : S_FORCED_TIMED;
    end else if (is_release || expire_c) begin
      state_d = S_UNFORCED;
    end
  end

  // Releasing keeps the forced value for one more edge; d_i is sampled only once unforced.
  always_comb begin
    q_d          = q_o;
    rsp_valid_d  = rsp_valid_o;
    rsp_status_d = status_e'(rsp_status_o);
    rsp_data_d   = rsp_data_o;
    if (is_force) begin
      q_d = cmd_value_i;
    end else if (!is_forced) begin
      q_d = d_i;
    end
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = '0;
      case (op)
        OP_FORCE:   rsp_status_d = ST_OK;
        OP_RELEASE: rsp_status_d = is_forced ? ST_OK : ST_NOT_FORCED;
        OP_READ: begin
          rsp_status_d = is_forced ? ST_FORCED : ST_OK;
          rsp_data_d   = read_data;
        end
        default:    rsp_status_d = ST_BAD_OP;
      endcase
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o          <= '0;
      forced_o     <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_status_o <= '0;
      rsp_data_o   <= '0;
    end else begin
      q_o          <= q_d;
      forced_o     <= (state_d != S_UNFORCED);
      rsp_valid_o  <= rsp_valid_d;
      rsp_status_o <= rsp_status_d;
      rsp_data_o   <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_force_release_responder.sv
// Randomized scoreboard bench for force_release_responder; honours
// FORCE_RESPONDER_STATS_EN when the design is built with it.
module tb_force_release_responder;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TIMER_W = 8;

  logic               clk;
  logic               rst_n;
  logic [WIDTH-1:0]   d_i, q_o, cmd_value_i, rsp_data_o;
  logic               forced_o, cmd_valid_i, cmd_ready_o, rsp_valid_o, rsp_ready_i;
  logic [1:0]         cmd_op_i, rsp_status_o;
  logic [TIMER_W-1:0] cmd_cycles_i;
`ifdef FORCE_RESPONDER_STATS_EN
  logic [15:0]        force_cnt_o;
`endif

  force_release_responder #(.WIDTH(WIDTH), .TIMER_W(TIMER_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .d_i          (d_i),
    .q_o          (q_o),
    .forced_o     (forced_o),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op_i),
    .cmd_value_i  (cmd_value_i),
    .cmd_cycles_i (cmd_cycles_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_status_o (rsp_status_o),
    .rsp_data_o   (rsp_data_o)
`ifdef FORCE_RESPONDER_STATS_EN
    ,
    .force_cnt_o  (force_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       status;
    logic [WIDTH-1:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: what the register holds, whether it is overridden,
  // how many edges of override remain (0 = indefinite), response pending.
  bit               m_forced;
  logic [WIDTH-1:0] m_q;
  int               m_left;
  bit               m_rvalid;
  int               m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_forced = 1'b0;
    m_q      = '0;
    m_left   = 0;
    m_rvalid = 1'b0;
    m_cnt    = 0;
    exp_q.delete();
  endtask

  function automatic logic [WIDTH-1:0] read_value();
`ifdef FORCE_RESPONDER_STATS_EN
    logic [15:0] c = 16'(m_cnt);
    return {c, m_q[15:0]};
`else
    return m_q;
`endif
  endfunction

  // Advance the model by one clock edge for the given inputs.
  task automatic model_step(input bit v, input logic [1:0] op, input logic [WIDTH-1:0] val,
                            input logic [TIMER_W-1:0] cyc, input logic [WIDTH-1:0] d, input bit rdy);
    bit               acc;
    bit               expire;
    logic [WIDTH-1:0] q_next;
    rsp_t             r;
    acc    = v && (!m_rvalid || rdy);
    expire = m_forced && (m_left == 1);
    q_next = m_forced ? m_q : d;
    if (acc) begin
      r.data = '0;
      case (op)
        2'd0: r.status = 2'd0;
        2'd1: r.status = m_forced ? 2'd0 : 2'd1;
        2'd2: begin
          r.status = m_forced ? 2'd2 : 2'd0;
          r.data   = read_value();
        end
        default: r.status = 2'd3;
      endcase
      exp_q.push_back(r);
    end
    m_rvalid = acc ? 1'b1 : (rdy ? 1'b0 : m_rvalid);
    if (acc && op == 2'd0) begin
      m_forced = 1'b1;
      m_left   = int'(cyc);
      q_next   = val;
      if (m_cnt < 65535) m_cnt++;
    end else if ((acc && op == 2'd1) || expire) begin
      m_forced = 1'b0;
      m_left   = 0;
    end else if (m_forced && m_left > 1) begin
      m_left--;
    end
    m_q = q_next;
  endtask

  // Entered just after a rising edge: drive, check at the falling edge, step the model.
  task automatic cycle(input bit v, input logic [1:0] op, input logic [WIDTH-1:0] val,
                       input logic [TIMER_W-1:0] cyc, input logic [WIDTH-1:0] d, input bit rdy);
    cmd_valid_i  = v;
    cmd_op_i     = op;
    cmd_value_i  = val;
    cmd_cycles_i = cyc;
    d_i          = d;
    rsp_ready_i  = rdy;
    @(negedge clk);
    check("q_o", 64'(q_o), 64'(m_q));
    check("forced_o", 64'(forced_o), 64'(m_forced));
    check("rsp_valid_o", 64'(rsp_valid_o), 64'(m_rvalid));
    check("cmd_ready_o", 64'(cmd_ready_o), 64'(!m_rvalid || rdy));
`ifdef FORCE_RESPONDER_STATS_EN
    check("force_cnt_o", 64'(force_cnt_o), 64'(m_cnt));
`endif
    model_step(v, op, val, cyc, d, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic [WIDTH-1:0] d);
    for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, '0, '0, d, 1'b1);
  endtask

  // Response monitor: every presented response must match the queue head and stay stable.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got status %0d data %0h, required no response", rsp_status_o, rsp_data_o);
        end else begin
          check("rsp_status", 64'(rsp_status_o), 64'(exp_q[0].status));
          check("rsp_data", 64'(rsp_data_o), 64'(exp_q[0].data));
          if (rsp_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    cmd_valid_i  = 1'b0;
    cmd_op_i     = '0;
    cmd_value_i  = '0;
    cmd_cycles_i = '0;
    d_i          = '0;
    rsp_ready_i  = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_q_o", 64'(q_o), 64'h0);
    check("rst_forced_o", 64'(forced_o), 64'h0);
    check("rst_rsp_valid_o", 64'(rsp_valid_o), 64'h0);
    check("rst_cmd_ready_o", 64'(cmd_ready_o), 64'h1);
    check("rst_rsp_status_o", 64'(rsp_status_o), 64'h0);
    check("rst_rsp_data_o", 64'(rsp_data_o), 64'h0);
    rst_n = 1'b1;

    // Normal follow, indefinite force, read while forced
    idle(3, 32'h5);
    cycle(1'b1, 2'd0, 32'hA, 8'd0, 32'h5, 1'b1);
    idle(10, 32'h5);
    cycle(1'b1, 2'd2, '0, '0, 32'h5, 1'b1);
    idle(1, 32'h5);

    // Release, then release while unforced
    cycle(1'b1, 2'd1, '0, '0, 32'h3, 1'b1);
    idle(2, 32'h3);
    cycle(1'b1, 2'd1, '0, '0, 32'h3, 1'b1);
    idle(1, 32'h3);

    // Timed force running out, then FORCE landing on the expiry edge
    cycle(1'b1, 2'd0, 32'h7, 8'd4, 32'h9, 1'b1);
    idle(6, 32'h9);
    cycle(1'b1, 2'd0, 32'h7, 8'd4, 32'h9, 1'b1);
    idle(3, 32'h9);
    cycle(1'b1, 2'd0, 32'hB, 8'd0, 32'h9, 1'b1);
    idle(2, 32'h9);

    // RELEASE and READ each landing on an expiry edge
    cycle(1'b1, 2'd0, 32'h11, 8'd2, 32'h9, 1'b1);
    idle(1, 32'h9);
    cycle(1'b1, 2'd1, '0, '0, 32'h9, 1'b1);
    idle(2, 32'h9);
    cycle(1'b1, 2'd0, 32'h22, 8'd2, 32'h9, 1'b1);
    idle(1, 32'h9);
    cycle(1'b1, 2'd2, '0, '0, 32'h9, 1'b1);
    idle(2, 32'h9);

    // Response stall with a command waiting, then reserved opcode
    cycle(1'b1, 2'd0, 32'h33, 8'd0, 32'h9, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 2'd2, '0, '0, 32'h9, 1'b0);
    cycle(1'b1, 2'd2, '0, '0, 32'h9, 1'b1);
    cycle(1'b1, 2'd3, '0, '0, 32'h9, 1'b1);
    idle(2, 32'h9);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int unsigned pick;
      logic [1:0] op;
      logic [TIMER_W-1:0] cyc;
      pick = $urandom_range(0, 99);
      op   = (pick < 30) ? 2'd0 : (pick < 55) ? 2'd1 : (pick < 85) ? 2'd2 : 2'd3;
      cyc  = ($urandom_range(0, 3) == 0) ? '0 : TIMER_W'($urandom_range(1, 6));
      cycle($urandom_range(0, 9) < 6, op, WIDTH'($urandom), cyc, WIDTH'($urandom),
            $urandom_range(0, 9) < 7);
    end
    idle(3, 32'h9);

    // Reset while a timed force is running
    cycle(1'b1, 2'd0, 32'h44, 8'd20, 32'h9, 1'b1);
    idle(3, 32'h9);
    rst_n = 1'b0;
    #1;
    check("midrst_q_o", 64'(q_o), 64'h0);
    check("midrst_forced_o", 64'(forced_o), 64'h0);
    check("midrst_rsp_valid_o", 64'(rsp_valid_o), 64'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4, 32'h6);
    cycle(1'b1, 2'd2, '0, '0, 32'h6, 1'b1);
    idle(3, 32'h6);
    check("rsp_drain", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
